dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 110 +++++++++++
 tb/tb_dm_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory; one access per BUSY cycle.
// Define DM_ARB_TRACE_EN to print a trace line for every write that reaches memory.
module dm_arbiter (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic [31:0] pc0,
   input  logic [31:0] pc1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        dm_memw,
   output logic        dm_memr,
   output logic [31:0] dm_add,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY0 = 2'd1;
   localparam logic [1:0] BUSY1 = 2'd2;

   logic [1:0] state;
   logic       ptr;     // 0: port 0 wins a tie, 1: port 1 wins
   logic       we_q;
   logic       gnt0, gnt1;

   // The port just served is excluded, so a BUSY exit can hand straight to the other port.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && (!req1 || !ptr)) gnt0 = 1'b1;
            else if (req1)               gnt1 = 1'b1;
         end
         BUSY0:   gnt1 = req1;
         BUSY1:   gnt0 = req0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state    <= IDLE;
         ptr      <= 1'b0;
         we_q     <= 1'b0;
         dm_add   <= '0;
         dm_wdata <= '0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         rdata0   <= '0;
         rdata1   <= '0;
      end else begin
         ack0 <= (state == BUSY0);
         ack1 <= (state == BUSY1);
         if (state == BUSY0 && !we_q) rdata0 <= dm_rdata;
         if (state == BUSY1 && !we_q) rdata1 <= dm_rdata;
         // dm_add/dm_wdata double as the request latch, so they hold while idle.
         if (gnt0) begin
            state    <= BUSY0;
            ptr      <= 1'b1;
            we_q     <= we0;
            dm_add   <= addr0;
            dm_wdata <= wdata0;
         end else if (gnt1) begin
            state    <= BUSY1;
            ptr      <= 1'b0;
            we_q     <= we1;
            dm_add   <= addr1;
            dm_wdata <= wdata1;
         end else begin
            state <= IDLE;
         end
      end
   end

   assign busy    = (state == BUSY0) || (state == BUSY1);
   assign dm_memw = busy &  we_q;
   assign dm_memr = busy & ~we_q;

`ifdef DM_ARB_TRACE_EN
   logic [31:0] pc_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)    pc_q <= '0;
      else if (gnt0) pc_q <= pc0;
      else if (gnt1) pc_q <= pc1;
   end

   // Each write occupies exactly one BUSY cycle, so this fires once per write.
   always @(posedge clk) begin
      if (clr_n && dm_memw)
         $display("%d@%h: *%h <= %h", $time, pc_q, dm_add, dm_wdata);
   end
`else
   logic unused_pc;
   assign unused_pc = ^{pc0, pc1};
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: memory model, ack scoreboard, immediate-assertion checks.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        req0, req1, we0, we1;
   logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
   logic        ack0, ack1, dm_memw, dm_memr, busy;
   logic [31:0] rdata0, rdata1, dm_add, dm_wdata, dm_rdata;

   typedef struct {
      logic        port;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] prev0, prev1;
   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   dm_arbiter dut (
      .clk(clk), .clr_n(clr_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .pc0(pc0), .pc1(pc1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .dm_memw(dm_memw), .dm_memr(dm_memr), .dm_add(dm_add), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .busy(busy)
   );

   assign dm_rdata = mem[dm_add[9:2]];
   always @(posedge clk) if (dm_memw) mem[dm_add[9:2]] <= dm_wdata;

   function automatic logic [31:0] pre(input logic [31:0] a);
      return 32'h5A00_0000 | {22'd0, a[9:2], 2'b00};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic p, input logic rd, input logic [31:0] d);
      exp_t e;
      e.port = p; e.rd = rd; e.data = d;
      sb.push_back(e);
   endtask

   task automatic check_acks();
      exp_t e;
      chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
      if (ack0 || ack1) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_port", 32'(ack1), 32'(e.port));
            if (e.rd) chk("ack_rdata", ack1 ? rdata1 : rdata0, e.data);
         end
      end
      if (!ack0) chk("rdata0_hold", rdata0, prev0);
      if (!ack1) chk("rdata1_hold", rdata1, prev1);
      prev0 = rdata0;
      prev1 = rdata1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_acks();
   endtask

   task automatic pulse_reset();
      clr_n = 1'b0;
      #2;
      sb.delete();
      prev0 = '0;
      prev1 = '0;
      clr_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, acks, cyc, last_ack0, last_ack1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | (32'(i) << 2);
      mem[4] = 32'hCAFE_BABE;
      clr_n = 1'b0;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; pc0 = '0; pc1 = '0;
      prev0 = '0; prev1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack0", 32'(ack0), 0);
      chk("rst_ack1", 32'(ack1), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_memw", 32'(dm_memw), 0);
      chk("rst_memr", 32'(dm_memr), 0);
      chk("rst_add", dm_add, 0);
      chk("rst_wdata", dm_wdata, 0);
      chk("rst_rdata0", rdata0, 0);
      chk("rst_rdata1", rdata1, 0);
      #2 clr_n = 1'b1;

      // single read, port 0
      req0 = 1; we0 = 0; addr0 = 32'h10;
      push(0, 1, 32'hCAFE_BABE);
      tick();
      chk("rd_busy", 32'(busy), 1);
      chk("rd_memr", 32'(dm_memr), 1);
      chk("rd_memw", 32'(dm_memw), 0);
      chk("rd_add", dm_add, 32'h10);
      chk("rd_noack", 32'(ack0), 0);
      tick();
      chk("rd_ack0", 32'(ack0), 1);
      chk("rd_rdata0", rdata0, 32'hCAFE_BABE);
      chk("rd_idle_memr", 32'(dm_memr), 0);
      chk("rd_idle_add_hold", dm_add, 32'h10);
      req0 = 0;
      tick();
      chk("rd_ack0_pulse", 32'(ack0), 0);
      chk("rd_idle", 32'(busy), 0);

      // simultaneous writes right after reset
      pulse_reset();
      req0 = 1; we0 = 1; addr0 = 32'h4; wdata0 = 32'h11;
      req1 = 1; we1 = 1; addr1 = 32'h8; wdata1 = 32'h22;
      push(0, 0, '0);
      push(1, 0, '0);
      tick();
      chk("sim_memw0", 32'(dm_memw), 1);
      chk("sim_add0", dm_add, 32'h4);
      chk("sim_wdata0", dm_wdata, 32'h11);
      tick();
      chk("sim_ack0", 32'(ack0), 1);
      chk("sim_memw1", 32'(dm_memw), 1);
      chk("sim_add1", dm_add, 32'h8);
      chk("sim_wdata1", dm_wdata, 32'h22);
      req0 = 0;
      tick();
      chk("sim_ack1", 32'(ack1), 1);
      chk("sim_ack0_low", 32'(ack0), 0);
      chk("sim_memw_off", 32'(dm_memw), 0);
      req1 = 0;
      tick();
      chk("sim_ack1_pulse", 32'(ack1), 0);
      chk("sim_mem1", mem[1], 32'h11);
      chk("sim_mem2", mem[2], 32'h22);

      // fairness: both ports continuously requesting reads
      n0 = 0; n1 = 0; acks = 0; last_ack0 = 0;
      req0 = 1; we0 = 0; addr0 = 32'h100; push(0, 1, pre(addr0)); n0++;
      req1 = 1; we1 = 0; addr1 = 32'h200; push(1, 1, pre(addr1)); n1++;
      for (cyc = 1; cyc <= 40 && acks < 8; cyc++) begin
         tick();
         if (ack0 || ack1) begin
            chk("fair_order", 32'(ack1), 32'(acks % 2));
            acks++;
         end
         if (ack0) begin
            last_ack0 = cyc;
            if (n0 < 4) begin addr0 = 32'h100 + 32'(n0) * 4; push(0, 1, pre(addr0)); n0++; end
            else req0 = 0;
         end
         if (ack1) begin
            chk("fair_wait", 32'(cyc - last_ack0 <= 2), 1);
            if (n1 < 4) begin addr1 = 32'h200 + 32'(n1) * 4; push(1, 1, pre(addr1)); n1++; end
            else req1 = 0;
         end
      end
      chk("fair_count", 32'(acks), 8);
      req0 = 0; req1 = 0;
      tick();

      // same port only: one access per two cycles
      n1 = 0; acks = 0; last_ack1 = 0;
      req1 = 1; we1 = 0; addr1 = 32'h300; push(1, 1, pre(addr1)); n1++;
      for (cyc = 1; cyc <= 20 && acks < 3; cyc++) begin
         tick();
         if (ack1) begin
            if (acks > 0) chk("same_gap", 32'(cyc - last_ack1), 2);
            last_ack1 = cyc;
            acks++;
            if (n1 < 3) begin addr1 = 32'h300 + 32'(n1) * 4; push(1, 1, pre(addr1)); n1++; end
            else req1 = 0;
         end
      end
      chk("same_count", 32'(acks), 3);

      // misaligned, out-of-range address passes through
      req1 = 1; we1 = 0; addr1 = 32'hFFFF_FFF3;
      push(1, 1, 32'h5A00_03F0);
      tick();
      chk("mis_add", dm_add, 32'hFFFF_FFF3);
      tick();
      chk("mis_ack1", 32'(ack1), 1);
      req1 = 0;
      tick();

      // reset during a BUSY1 write aborts it
      req1 = 1; we1 = 1; addr1 = 32'h20; wdata1 = 32'h5;
      push(1, 0, '0);
      tick();
      chk("abort_memw_before", 32'(dm_memw), 1);
      #2 clr_n = 1'b0;
      #1;
      chk("abort_memw", 32'(dm_memw), 0);
      chk("abort_memr", 32'(dm_memr), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_ack1", 32'(ack1), 0);
      chk("abort_add", dm_add, 0);
      chk("abort_wdata", dm_wdata, 0);
      chk("abort_rdata0", rdata0, 0);
      chk("abort_rdata1", rdata1, 0);
      sb.delete();
      prev0 = '0; prev1 = '0;
      req1 = 0;
      tick();
      chk("abort_no_ack", 32'(ack1), 0);
      chk("abort_mem", mem[8], 32'h5A00_0020);

      // first edge after release arbitrates normally
      req0 = 1; we0 = 0; addr0 = 32'h14;
      push(0, 1, pre(addr0));
      clr_n = 1'b1;
      tick();
      chk("rel_busy", 32'(busy), 1);
      chk("rel_add", dm_add, 32'h14);
      tick();
      chk("rel_ack0", 32'(ack0), 1);
      req0 = 0;
      tick();
      chk("sb_drained", 32'(sb.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
